// File: rtl/signed_mac_accumulator_pkg.sv
// Shared types and helpers for the signed multiply-accumulate stage:
// the two-state handshake FSM encoding and the saturation bounds helper.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    // Bounds are carried in a wide container so any accumulator width up to
    // BOUND_W-1 bits can be described; users slice down to their own width.
    localparam int BOUND_W = 128;

    typedef struct packed {
        logic signed [BOUND_W-1:0] max_val;
        logic signed [BOUND_W-1:0] min_val;
    } sat_bounds_t;

    // Largest and smallest two's-complement values representable in acc_w bits.
    function automatic sat_bounds_t sat_bounds(input int acc_w);
        sat_bounds_t b;
        b.max_val = $signed((BOUND_W'(1) << (acc_w - 1)) - BOUND_W'(1));
        b.min_val = -$signed(BOUND_W'(1) << (acc_w - 1));
        return b;
    endfunction

endpackage

// File: rtl/signed_mac_accumulator_sat_adder.sv
// Combinational signed W-bit adder that clamps to the W-bit range instead of
// wrapping, flagging whenever the clamp was applied.
module sat_adder
    import mac_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam sat_bounds_t BOUNDS = sat_bounds(W);
    localparam logic signed [W:0] MAX_EXT = BOUNDS.max_val[W:0];
    localparam logic signed [W:0] MIN_EXT = BOUNDS.min_val[W:0];

    logic signed [W:0] nsum;

    // One extra bit of headroom makes the true sum exact, so the clamp
    // decision is a plain signed compare against the range limits.
    always_comb begin
        nsum = {a[W-1], a} + {b[W-1], b};
        sum  = nsum[W-1:0];
        ovf  = 1'b0;
        if (nsum > MAX_EXT) begin
            sum = MAX_EXT[W-1:0];
            ovf = 1'b1;
        end else if (nsum < MIN_EXT) begin
            sum = MIN_EXT[W-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/signed_mac_accumulator.sv
// Streaming dot-product stage: sums signed products until in_last, then holds
// the saturated sum, term count and overflow flag until downstream takes it.
module signed_mac_accumulator
    import mac_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int ACC_W = 2*SIZE+8,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*SIZE-1:0]       in_product,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [LEN_W-1:0]        out_count,
    output logic                    out_overflow
);

    mac_state_t state;
    mac_state_t state_next;

    logic signed [ACC_W-1:0] acc;
    logic [LEN_W-1:0]        count;
    logic                    ovf;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic [LEN_W-1:0]        count_inc;
    logic                    accept;

    assign prod_ext  = ACC_W'($signed(in_product));
    assign count_inc = (&count) ? count : count + LEN_W'(1);
    assign accept    = in_valid & in_ready;

    sat_adder #(
        .W (ACC_W)
    ) u_sat_adder (
        .a   (acc),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // State register; reset lands in ACCUM with nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs, decoded from the registered state only
    // (reset gates in_ready so nothing is taken while reset is held).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = ~rst;
                if (accept && in_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Accumulator and result registers: partial sums build up in acc/count/ovf,
    // and the final term moves the completed totals into the out_* holding
    // registers while clearing the running state for the next vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                out_sum      <= add_sum;
                out_count    <= count_inc;
                out_overflow <= ovf | add_ovf;
                acc          <= '0;
                count        <= '0;
                ovf          <= 1'b0;
            end else begin
                acc   <= add_sum;
                count <= count_inc;
                ovf   <= ovf | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Scoreboard bench for signed_mac_accumulator with SIZE=4, ACC_W=10, LEN_W=4.
module tb_signed_mac_accumulator;

    localparam int SIZE  = 4;
    localparam int ACC_W = 10;
    localparam int LEN_W = 4;

    typedef struct {
        logic signed [ACC_W-1:0] sum;
        logic [LEN_W-1:0]        count;
        logic                    ovf;
    } result_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [2*SIZE-1:0]       in_product;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [LEN_W-1:0]        out_count;
    logic                    out_overflow;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    result_t sb[$];

    signed_mac_accumulator #(
        .SIZE  (SIZE),
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int sum, input int count, input int ovf);
        result_t r;
        r.sum   = ACC_W'(sum);
        r.count = LEN_W'(count);
        r.ovf   = ovf[0];
        sb.push_back(r);
    endtask

    // Presents one term and returns #1 after the edge on which it was accepted.
    task automatic applyStimulus(input int p, input logic last);
        logic rdy;
        int   guard;
        in_valid   = 1'b1;
        in_product = (2*SIZE)'(p);
        in_last    = last;
        guard      = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 50);
        if (!rdy) checkOutput("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops an expectation when a new result appears, then checks
    // the held result stays stable until the output handshake.
    logic                    holding = 1'b0;
    logic signed [ACC_W-1:0] held_sum;
    logic [LEN_W-1:0]        held_count;
    logic                    held_ovf;

    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else if (out_valid) begin
            if (!holding) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    result_t e;
                    e = sb.pop_front();
                    checkOutput("out_sum", int'(out_sum), int'(e.sum));
                    checkOutput("out_count", int'(out_count), int'(e.count));
                    checkOutput("out_overflow", int'(out_overflow), int'(e.ovf));
                end
                holding    = 1'b1;
                held_sum   = out_sum;
                held_count = out_count;
                held_ovf   = out_overflow;
            end else begin
                checkOutput("hold_sum_stable", int'(out_sum), int'(held_sum));
                checkOutput("hold_count_stable", int'(out_count), int'(held_count));
                checkOutput("hold_ovf_stable", int'(out_overflow), int'(held_ovf));
                checkOutput("hold_in_ready", int'(in_ready), 0);
            end
            if (out_ready) holding = 1'b0;
        end
    end

    initial begin
        int c0;
        int guard;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        idle(2);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_sum", int'(out_sum), 0);
        checkOutput("rst_out_count", int'(out_count), 0);
        checkOutput("rst_out_overflow", int'(out_overflow), 0);
        rst = 1'b0;
        idle(1);
        checkOutput("idle_in_ready", int'(in_ready), 1);

        $display("[TB] basic vector 3,-5,7");
        pushExpected(5, 3, 0);
        applyStimulus(3, 1'b0);
        applyStimulus(-5, 1'b0);
        idle(2);
        applyStimulus(7, 1'b1);
        checkOutput("latency_out_valid", int'(out_valid), 1);
        checkOutput("latency_in_ready", int'(in_ready), 0);
        idle(2);

        $display("[TB] positive saturation");
        pushExpected(511, 10, 1);
        for (int i = 0; i < 10; i++) applyStimulus(64, i == 9);
        idle(2);

        $display("[TB] negative saturation");
        pushExpected(-512, 10, 1);
        for (int i = 0; i < 10; i++) applyStimulus(-56, i == 9);
        idle(2);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        pushExpected(3, 2, 0);
        applyStimulus(1, 1'b0);
        applyStimulus(2, 1'b1);
        idle(5);
        checkOutput("bp_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        idle(1);
        checkOutput("bp_release_in_ready", int'(in_ready), 1);
        pushExpected(4, 1, 0);
        applyStimulus(4, 1'b1);
        idle(2);

        $display("[TB] single-term vectors");
        pushExpected(-8, 1, 0);
        applyStimulus(-8, 1'b1);
        idle(2);
        pushExpected(2, 1, 0);
        pushExpected(-3, 1, 0);
        pushExpected(5, 1, 0);
        c0 = cycle;
        applyStimulus(2, 1'b1);
        applyStimulus(-3, 1'b1);
        applyStimulus(5, 1'b1);
        checkOutput("b2b_cycles", cycle - c0, 5);
        idle(2);

        $display("[TB] count saturation");
        pushExpected(20, 15, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, i == 19);
        idle(2);

        $display("[TB] reset mid-vector");
        applyStimulus(9, 1'b0);
        applyStimulus(9, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", int'(in_ready), 0);
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        idle(1);
        rst = 1'b0;
        idle(1);
        pushExpected(3, 2, 0);
        applyStimulus(1, 1'b0);
        applyStimulus(2, 1'b1);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            idle(1);
            guard++;
        end
        idle(2);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_mac_accumulator.md
# signed_mac_accumulator

Streaming signed accumulator directly downstream of the combinational signed multiplier. Consumes one 2*SIZE-bit two's-complement product per cycle over a valid/ready handshake and sums a vector of products terminated by `in_last`. Presents the saturated dot-product result, term count and an overflow flag on an output valid/ready port. It converts the multiplier's product stream into a pipelined dot-product stage.

## Interface
- `SIZE`, 32: operand width of the upstream multiplier; the product is 2*SIZE bits.
- `ACC_W`, 2*SIZE+8: accumulator width; must be >= 2*SIZE+1.
- `LEN_W`, 8: width of the term counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_product` / `in_last` are valid.
- `in_ready`  out  1  block accepts a term this cycle.
- `in_product`  in  2*SIZE  signed product from the multiplier.
- `in_last`  in  1  this term ends the current vector.
- `out_valid`  out  1  result is held on the out_* ports.
- `out_ready`  in  1  downstream consumes the result.
- `out_sum`  out  ACC_W  signed saturated sum.
- `out_count`  out  LEN_W  number of terms in the vector, including the last.
- `out_overflow`  out  1  saturation occurred at least once in this vector.

## Operation
- FSM with two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Reset state is ACCUM.
  - While `rst` is high: `in_ready`=0, `out_valid`=0; `acc`, `count`, `ovf`, `out_sum`, `out_count` and `out_overflow` are all 0.
- Accept is `in_valid & in_ready`. On accept:
  - Sign-extend `in_product` to ACC_W bits.
  - `nsum` = `acc` + extended product, computed in ACC_W+1 bits.
  - If `nsum` exceeds 2^(ACC_W-1)-1, clamp to that value. If it is below -2^(ACC_W-1), clamp to that value. Either clamp sets `ovf`.
  - `count` increments, saturating at 2^LEN_W-1.
- Accept with `in_last`=0: `acc`, `count` and `ovf` are updated; the state stays ACCUM.
- Accept with `in_last`=1:
  - `out_sum`, `out_count` and `out_overflow` load the updated values, including this term.
  - `acc`, `count` and `ovf` clear to 0.
  - The state moves to HOLD.
- HOLD:
  - The out_* ports are stable until `out_valid & out_ready`.
  - On that handshake the state returns to ACCUM next cycle, and `out_valid` drops.
- A single-term vector (first accepted term has `in_last`=1) yields that term's sign-extended value with `out_count`=1.
- Cycles with `in_valid`=0 in ACCUM leave all state unchanged; bubbles are allowed mid-vector.
- While `in_ready`=0, `in_product`/`in_last` are ignored and the upstream must hold them.
- Reset asserted mid-vector or in HOLD discards the partial sum and any pending result without emitting it.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid`/`out_ready` to either output.
- Latency: `out_valid` rises the cycle after the `in_last` accept.
- Throughput:
  - One term per cycle within a vector.
  - At least one HOLD cycle between vectors, so minimum vector period is N+1 cycles for N terms.
- With `out_ready` tied high, HOLD lasts exactly 1 cycle.
- The `in_last` accept and the HOLD→ACCUM transition never coincide, because `in_ready`=0 in HOLD.
- The single-cycle critical path is the ACC_W+1-bit add plus the clamp mux.

## Structure
- Package `mac_pkg`:
  - `mac_state_t` enum {ACCUM, HOLD}.
  - Function `sat_bounds(ACC_W)` returning the max/min constants.
- Sub-module `sat_adder #(W)`: combinational signed W-bit add.
  - Outputs: clamped sum and an overflow bit.
  - The main block instantiates it once for the accumulate path.
- The main block contains the FSM, the acc/count/ovf registers and the output registers.

## Test plan
All scenarios use SIZE=4, ACC_W=10, LEN_W=4 unless noted.
- Vector of products 3, -5, 7, `in_last` on the third -> `out_sum`=5, `out_count`=3, `out_overflow`=0; `out_valid` 1 cycle after the last accept.
- 10 products of +64 -> after term 8 (512) the sum clamps to 511; final `out_sum`=511, `out_overflow`=1, `out_count`=10. Ten products of -56 -> -512 clamp, `out_overflow`=1.
- Backpressure: `out_ready`=0 for 5 cycles in HOLD -> `in_ready`=0 and out_* stable throughout; the handshake on cycle 6 returns to ACCUM, and the next vector starts clean (sum 0, count 0).
- Single-term vector: product -8 with `in_last` -> `out_sum`=-8, `out_count`=1; back-to-back single-term vectors sustain 1 result every 2 cycles with `out_ready`=1.
- Count saturation: 20 terms of +1 with LEN_W=4 -> `out_count`=15, `out_sum`=20.
- `rst` pulse after 2 of 4 terms -> no `out_valid`; a following 2-term vector {1, 2} yields `out_sum`=3, `out_count`=2.
